// File: rtl/cfg_reg_arbiter.sv
// Round-robin write arbiter between the SPI decoder (r0) and the default/ramp loader (r1)
// in front of the five-entry output-enable / PWM configuration register bank.
module cfg_reg_arbiter #(
  parameter int MAX_ADDRESS = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_wr,
  input  logic [6:0]       r0_addr,
  input  logic [7:0]       r0_data,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_wr,
  input  logic [6:0]       r1_addr,
  input  logic [7:0]       r1_data,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             busy,
  output logic             grant_id,
  output logic             commit_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;

  typedef enum logic {IDLE, COMMIT} state_e;

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               grant_id_q, grant_id_d;
  logic               hold_wr_q, hold_wr_d;
  logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];
  logic               commit_pulse_q, commit_pulse_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic gnt_sel, hs, addr_ok;

  // With both requesters pending the pointer decides; otherwise whoever is valid wins.
  assign gnt_sel  = (r0_valid & r1_valid) ? rr_ptr_q : r1_valid;
  assign r0_ready = ~rst & (state_q == IDLE) & r0_valid & ~gnt_sel;
  assign r1_ready = ~rst & (state_q == IDLE) & r1_valid &  gnt_sel;
  assign hs       = r0_ready | r1_ready;
  assign addr_ok  = (hold_addr_q <= ADDR_W'(MAX_ADDRESS)) && (hold_addr_q < ADDR_W'(NUM_REGS));

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    hold_wr_d      = hold_wr_q;
    hold_addr_d    = hold_addr_q;
    hold_data_d    = hold_data_q;
    regs_d         = regs_q;
    commit_pulse_d = 1'b0;
    err_pulse_d    = 1'b0;
    err_count_d    = err_count_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          hold_wr_d   = gnt_sel ? r1_wr   : r0_wr;
          hold_addr_d = gnt_sel ? r1_addr : r0_addr;
          hold_data_d = gnt_sel ? r1_data : r0_data;
          grant_id_d  = gnt_sel;
          rr_ptr_d    = ~gnt_sel;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (hold_wr_q) begin
          if (addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (hold_addr_q == ADDR_W'(i)) regs_d[i] = hold_data_q;
            commit_pulse_d = 1'b1;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over a pending COMMIT, so a held transaction is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= 1'b0;
      grant_id_q     <= 1'b0;
      hold_wr_q      <= 1'b0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      commit_pulse_q <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      hold_wr_q      <= hold_wr_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
      regs_q         <= regs_d;
      commit_pulse_q <= commit_pulse_d;
      err_pulse_q    <= err_pulse_d;
      err_count_q    <= err_count_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign busy            = (state_q == COMMIT);
  assign grant_id        = grant_id_q;
  assign commit_pulse    = commit_pulse_q;
  assign err_pulse       = err_pulse_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Bench for cfg_reg_arbiter: per-scenario tasks plus a scoreboard of expected
// commits/errors that a monitor retires on each commit_pulse / err_pulse.
module tb_cfg_reg_arbiter;

  logic       clk, rst;
  logic       r0_valid, r0_ready, r0_wr;
  logic [6:0] r0_addr;
  logic [7:0] r0_data;
  logic       r1_valid, r1_ready, r1_wr;
  logic [6:0] r1_addr;
  logic [7:0] r1_data;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       busy, grant_id, commit_pulse, err_pulse;
  logic [7:0] err_count;

  cfg_reg_arbiter #(.MAX_ADDRESS(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_data(r1_data),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .busy(busy), .grant_id(grant_id),
    .commit_pulse(commit_pulse), .err_pulse(err_pulse), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    int         idx;
    logic [7:0] val;
    logic [7:0] errc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_regs [5];
  int         m_err;

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  function automatic bit regs_match();
    for (int i = 0; i < 5; i++) if (dut_reg(i) !== m_regs[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_push(input bit wr, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0; e.idx = 0; e.val = 8'h00; e.errc = 8'h00;
    if (wr && a <= 7'd4) begin
      m_regs[int'(a)] = d;
      e.idx = int'(a); e.val = d;
      sb.push_back(e);
    end else if (wr) begin
      if (m_err < 255) m_err++;
      e.is_err = 1'b1; e.errc = m_err[7:0];
      sb.push_back(e);
    end
  endtask

  // Scoreboard retirement
  always @(negedge clk) begin : monitor
    exp_t e;
    if (commit_pulse || err_pulse) begin
      checks++;
      if (commit_pulse && err_pulse) begin
        errors++; $display("FAIL pulse_overlap: commit and err pulses both high");
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL unexpected_pulse: commit=%0b err=%0b with empty scoreboard", commit_pulse, err_pulse);
      end else begin
        e = sb.pop_front();
        if (e.is_err != err_pulse) begin
          errors++; $display("FAIL sb_kind: got err_pulse=%0b expected err=%0b", err_pulse, e.is_err);
        end else if (e.is_err && err_count !== e.errc) begin
          errors++; $display("FAIL sb_err_count: got %0d expected %0d", err_count, e.errc);
        end else if (!e.is_err && dut_reg(e.idx) !== e.val) begin
          errors++; $display("FAIL sb_reg%0d: got %02h expected %02h", e.idx, dut_reg(e.idx), e.val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_err = 0;
    sb.delete();
  endtask

  // Caller is just after a posedge; returns just after the handshake edge.
  task automatic send(input int r, input bit wr, input logic [6:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    if (r == 0) begin r0_valid = 1'b1; r0_wr = wr; r0_addr = a; r0_data = d; end
    else        begin r1_valid = 1'b1; r1_wr = wr; r1_addr = a; r1_data = d; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((r == 0) ? r0_ready : r1_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL send_timeout: r%0d ready=0 expected 1 within 20 cycles", r);
    end else begin
      model_push(wr, a, d);
      @(posedge clk);
    end
    #1;
    if (r == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    r0_wr = 1'b1; r1_wr = 1'b1; r0_addr = 7'd0; r1_addr = 7'd0; r0_data = 8'h11; r1_data = 8'h22;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got r0=%0b r1=%0b expected 0 0", r0_ready, r1_ready);
    end
    checks++;
    if (!regs_match() || err_count !== 8'h00) begin
      errors++; $display("FAIL reset_regs: got %02h %02h %02h %02h %02h err=%0d expected all 0",
        en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, err_count);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 1'b0 || commit_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%0b gid=%0b cp=%0b ep=%0b expected 0 0 0 0",
        busy, grant_id, commit_pulse, err_pulse);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 7'h02; r0_data = 8'hA5;
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got r0=%0b r1=%0b expected 1 0", r0_ready, r1_ready);
    end
    model_push(1'b1, 7'h02, 8'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b0 || busy !== 1'b1 || grant_id !== 1'b0 || en_reg_pwm_7_0 !== 8'h00) begin
      errors++; $display("FAIL single_commit_cycle: got ready=%0b busy=%0b gid=%0b pwm0=%02h expected 0 1 0 00",
        r0_ready, busy, grant_id, en_reg_pwm_7_0);
    end
    r0_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (en_reg_pwm_7_0 !== 8'hA5 || commit_pulse !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_landed: got pwm0=%02h cp=%0b busy=%0b expected a5 1 0",
        en_reg_pwm_7_0, commit_pulse, busy);
    end
    @(negedge clk);
    checks++;
    if (commit_pulse !== 1'b0 || en_reg_pwm_7_0 !== 8'hA5) begin
      errors++; $display("FAIL single_pulse_width: got cp=%0b pwm0=%02h expected 0 a5", commit_pulse, en_reg_pwm_7_0);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d0, d1;
    int         exp_id;
    do_reset();
    d0 = 8'h80; d1 = 8'h20;
    r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 7'h04; r0_data = d0;
    r1_valid = 1'b1; r1_wr = 1'b1; r1_addr = 7'h04; r1_data = d1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      @(negedge clk);
      checks++;
      if (pwm_duty_cycle !== m_regs[4]) begin
        errors++; $display("FAIL rr_duty%0d: got %02h expected %02h", k, pwm_duty_cycle, m_regs[4]);
      end
      checks++;
      if (r0_ready !== (exp_id == 0) || r1_ready !== (exp_id == 1)) begin
        errors++; $display("FAIL rr_grant%0d: got r0=%0b r1=%0b expected grant %0d", k, r0_ready, r1_ready, exp_id);
      end
      model_push(1'b1, 7'h04, (exp_id == 1) ? d1 : d0);
      @(posedge clk); #1;
      if (exp_id == 0) begin d0 = d0 + 8'd1; r0_data = d0; end
      else             begin d1 = d1 + 8'd1; r1_data = d1; end
      @(negedge clk);
      checks++;
      if (grant_id !== exp_id[0] || busy !== 1'b1 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++; $display("FAIL rr_commit%0d: got gid=%0b busy=%0b r0=%0b r1=%0b expected gid=%0d busy=1 ready 0",
          k, grant_id, busy, r0_ready, r1_ready, exp_id);
      end
      @(posedge clk); #1;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_duty_cycle !== 8'h21) begin
      errors++; $display("FAIL rr_final_duty: got %02h expected 21", pwm_duty_cycle);
    end
  endtask

  task automatic test_err_saturation();
    @(posedge clk); #1;
    send(1, 1'b1, 7'h05, 8'hFF);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || commit_pulse !== 1'b0 || !regs_match()) begin
      errors++; $display("FAIL err_first: got ep=%0b cnt=%0d cp=%0b regs_ok=%0b expected 1 1 0 1",
        err_pulse, err_count, commit_pulse, regs_match());
    end
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width: got %0b expected 0", err_pulse);
    end
    @(posedge clk); #1;
    for (int i = 1; i < 300; i++) send(i % 2, 1'b1, 7'(5 + (i % 123)), 8'(i));
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (err_count !== 8'hFF || !regs_match()) begin
      errors++; $display("FAIL err_saturate: got cnt=%0d regs_ok=%0b expected 255 1", err_count, regs_match());
    end
  endtask

  task automatic test_read_noop();
    @(posedge clk); #1;
    send(0, 1'b1, 7'h01, 8'h5A);
    send(0, 1'b0, 7'h01, 8'hC3);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (commit_pulse !== 1'b0 || err_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_pulses: got cp=%0b ep=%0b busy=%0b expected 0 0 0", commit_pulse, err_pulse, busy);
    end
    @(negedge clk);
    checks++;
    if (en_reg_out_15_8 !== 8'h5A || !regs_match()) begin
      errors++; $display("FAIL read_nochange: got out_15_8=%02h expected 5a", en_reg_out_15_8);
    end
  endtask

  task automatic test_reset_in_commit();
    do_reset();
    r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 7'h00; r0_data = 8'h3C;
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b1) begin
      errors++; $display("FAIL rstc_ready: got %0b expected 1", r0_ready);
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (en_reg_out_7_0 !== 8'h00 || err_count !== 8'h00 || busy !== 1'b0 || commit_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL rstc_discard: got reg0=%02h cnt=%0d busy=%0b cp=%0b ep=%0b expected 00 0 0 0 0",
        en_reg_out_7_0, err_count, busy, commit_pulse, err_pulse);
    end
    @(posedge clk); #1;
    send(1, 1'b1, 7'h00, 8'h11);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (en_reg_out_7_0 !== 8'h11 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rstc_recover: got reg0=%02h gid=%0b expected 11 1", en_reg_out_7_0, grant_id);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_err = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_err_saturation();
    test_read_noop();
    test_reset_in_commit();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_reg_arbiter.md
Name: cfg_reg_arbiter

Overview:
Shares the five-entry configuration register bank (output enables, PWM enables, PWM duty cycle) between two write requesters: requester 0 is the SPI frame decoder and requester 1 is the on-chip default/ramp loader. Each requester uses a valid/ready handshake. A round-robin arbiter grants one transaction at a time and commits it into the bank. Out-of-range addresses are rejected and counted.

Parameters:
MAX_ADDRESS, 4, highest valid register address; addresses above it are errors.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
r0_valid  in  1  requester 0 (SPI) has a transaction
r0_ready  out  1  requester 0 transaction accepted this cycle
r0_wr  in  1  1 = write, 0 = read (read is a no-op)
r0_addr  in  7  register address
r0_data  in  8  write data
r1_valid, r1_ready, r1_wr, r1_addr, r1_data  same as the r0 set, for requester 1 (loader)
en_reg_out_7_0  out  8  register at address 0x00
en_reg_out_15_8  out  8  register at address 0x01
en_reg_pwm_7_0  out  8  register at address 0x02
en_reg_pwm_15_8  out  8  register at address 0x03
pwm_duty_cycle  out  8  register at address 0x04
busy  out  1  high while in COMMIT
grant_id  out  1  requester whose transaction was last accepted
commit_pulse  out  1  one-cycle pulse when a valid write lands
err_pulse  out  1  one-cycle pulse when an out-of-range address is rejected
err_count  out  ERR_W  saturating count of rejected transactions

Behaviour:
- Reset (sync, rst high at a clk edge):
  - All five registers = 0x00; err_count = 0.
  - busy, commit_pulse, err_pulse, grant_id = 0.
  - Round-robin pointer rr_ptr = 0; state = IDLE.
  - While rst is high, r0_ready and r1_ready are 0.
- States: IDLE and COMMIT only.
- IDLE arbitration:
  - Only r0_valid high: grant 0. Only r1_valid high: grant 1.
  - Both high: grant rr_ptr.
  - rX_ready is combinational: high only in IDLE, only for the granted X, and only when rX_valid is high. Never both high in the same cycle.
- Handshake at edge N (rX_valid and rX_ready both high):
  - Capture wr, addr and data into hold registers.
  - grant_id <= X; rr_ptr <= ~X; state <= COMMIT.
- COMMIT (one cycle, busy = 1, both ready = 0):
  - wr = 1 and addr <= MAX_ADDRESS: write data to the matching register at edge N+1; commit_pulse high during the cycle after N+1.
  - wr = 1 and addr > MAX_ADDRESS: no register change. err_count increments at N+1, saturating at all-ones; err_pulse high during the cycle after N+1.
  - wr = 0: no change, no pulse, no error, regardless of address.
  - Always return to IDLE at edge N+1.
- Timing:
  - Throughput is one transaction per 2 cycles.
  - Write-to-output latency is 1 cycle after the handshake edge.
  - A new grant can occur in the IDLE cycle directly after COMMIT.
- Requester rules:
  - A requester holds valid and payload stable until ready. The arbiter does not check this.
  - Dropping valid before ready cancels the request with no side effects.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... No requester waits more than one other transaction.
- Registers hold their value indefinitely between writes; reads never alter state.
- Reset during COMMIT: the held transaction is discarded (no write, no err increment) and all state returns to reset values.

Test Plan:
1. Reset -> all registers 0x00, err_count 0, rr_ptr 0, both ready low while rst high, busy low.
2. r0 write addr 0x02 data 0xA5 -> r0_ready high for exactly 1 cycle; en_reg_pwm_7_0 = 0xA5 one edge after the handshake; commit_pulse 1 cycle; grant_id 0.
3. r0 (addr 0x04, data 0x80) and r1 (addr 0x04, data 0x20) valid in the same cycle from reset -> r0 granted first, r1 two cycles later; pwm_duty_cycle reads 0x80 then 0x20; a third simultaneous pair is granted to r0 again (alternation).
4. r1 write addr 0x05 data 0xFF -> no register change, err_pulse 1 cycle, err_count 1; after 300 such transactions err_count saturates at 0xFF.
5. r0 with wr 0, addr 0x01 -> handshake completes, en_reg_out_15_8 unchanged, no commit_pulse, no err_pulse.
6. Handshake on r0 (addr 0x00, data 0x3C) with rst asserted in the COMMIT cycle -> en_reg_out_7_0 stays 0x00, err_count 0, state IDLE after reset.
